// File: rtl/cpu16_bus_arbiter_if.sv
// rtl/cpu16_bus_arbiter_if.sv - CPU16 / DMA / memory bus signal bundle for the bus arbiter
interface cpu16_bus_arbiter_if;
    // CPU16 side
    logic        cpu_busy;
    logic [15:0] cpu_address;
    logic [15:0] cpu_dataOut;
    logic        cpu_write;
    logic        cpu_hold;

    // DMA-style requester side
    logic        dma_req;
    logic [15:0] dma_address;
    logic [15:0] dma_dataOut;
    logic        dma_write;
    logic        dma_gnt;

    // Memory side; read data fans out to both masters outside the arbiter
    logic [15:0] mem_address;
    logic [15:0] mem_dataOut;
    logic        mem_write;
    logic [15:0] mem_dataIn;

    // Arbiter view: observes both masters, drives hold/grant and the muxed bus
    modport slave (
        input  cpu_busy,
        input  cpu_address,
        input  cpu_dataOut,
        input  cpu_write,
        output cpu_hold,
        input  dma_req,
        input  dma_address,
        input  dma_dataOut,
        input  dma_write,
        output dma_gnt,
        output mem_address,
        output mem_dataOut,
        output mem_write
    );

    // Environment view: the masters and the memory around the arbiter
    modport master (
        output cpu_busy,
        output cpu_address,
        output cpu_dataOut,
        output cpu_write,
        input  cpu_hold,
        output dma_req,
        output dma_address,
        output dma_dataOut,
        output dma_write,
        input  dma_gnt,
        input  mem_address,
        input  mem_dataOut,
        input  mem_write,
        output mem_dataIn
    );
endinterface

// File: rtl/cpu16_bus_arbiter.sv
// rtl/cpu16_bus_arbiter.sv - CPU16 / DMA bus arbiter with bounded bursts and CPU guard window
module cpu16_bus_arbiter #(
    parameter int MAX_BURST = 16,
    parameter int CPU_SLOTS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu16_bus_arbiter_if.slave   bus
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int GUARD_W = (CPU_SLOTS > 0) ? $clog2(CPU_SLOTS + 1) : 1;

    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [BURST_W-1:0] BURST_TOP  = BURST_W'(MAX_BURST);
    localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(CPU_SLOTS);

    typedef enum logic [1:0] {
        CPU_RUN   = 2'd0,
        HOLD_WAIT = 2'd1,
        DMA_RUN   = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [GUARD_W-1:0] guard_q, guard_d;

    // State, burst counter and guard counter registers; async reset parks the bus on the CPU
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CPU_RUN;
            burst_q <= '0;
            guard_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            guard_q <= guard_d;
        end
    end

    // Next-state logic: request accepted only once the guard window has drained
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        guard_d = guard_q;
        case (state_q)
            CPU_RUN: begin
                if (guard_q != '0) begin
                    guard_d = guard_q - GUARD_W'(1);
                end
                if (bus.dma_req && (guard_q == '0)) begin
                    state_d = HOLD_WAIT;
                end
            end
            HOLD_WAIT: begin
                // A withdrawn request wins over a CPU that happens to park this cycle
                if (!bus.dma_req) begin
                    state_d = RELEASE;
                end else if (!bus.cpu_busy) begin
                    state_d = DMA_RUN;
                    burst_d = '0;
                end
            end
            DMA_RUN: begin
                if (burst_q != BURST_TOP) begin
                    burst_d = burst_q + BURST_W'(1);
                end
                if (!bus.dma_req || (burst_q == BURST_LAST)) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                guard_d = GUARD_LOAD;
                state_d = CPU_RUN;
            end
            default: begin
                state_d = CPU_RUN;
            end
        endcase
    end

    // Output mux decoded from the state register only, so hold/grant never glitch on req/busy
    always_comb begin
        bus.cpu_hold    = 1'b0;
        bus.dma_gnt     = 1'b0;
        bus.mem_address = bus.cpu_address;
        bus.mem_dataOut = bus.cpu_dataOut;
        bus.mem_write   = bus.cpu_write;
        case (state_q)
            HOLD_WAIT: begin
                bus.cpu_hold = 1'b1;
            end
            DMA_RUN: begin
                bus.cpu_hold    = 1'b1;
                bus.dma_gnt     = 1'b1;
                bus.mem_address = bus.dma_address;
                bus.mem_dataOut = bus.dma_dataOut;
                bus.mem_write   = bus.dma_write;
            end
            RELEASE: begin
                // CPU owns the address lines again but must not write during the handover
                bus.mem_write = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cpu16_bus_arbiter.sv
// tb/tb_cpu16_bus_arbiter.sv - self-checking bench for cpu16_bus_arbiter
module tb_cpu16_bus_arbiter;

    localparam int MAXB = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        busy;
    logic [15:0] caddr, cdata;
    logic        cwr;
    logic        req;
    logic [15:0] daddr, ddata;
    logic        dwr;
    logic [15:0] mdin;

    cpu16_bus_arbiter_if bus_a ();
    cpu16_bus_arbiter_if bus_z ();

    assign bus_a.cpu_busy    = busy;
    assign bus_a.cpu_address = caddr;
    assign bus_a.cpu_dataOut = cdata;
    assign bus_a.cpu_write   = cwr;
    assign bus_a.dma_req     = req;
    assign bus_a.dma_address = daddr;
    assign bus_a.dma_dataOut = ddata;
    assign bus_a.dma_write   = dwr;
    assign bus_a.mem_dataIn  = mdin;

    assign bus_z.cpu_busy    = busy;
    assign bus_z.cpu_address = caddr;
    assign bus_z.cpu_dataOut = cdata;
    assign bus_z.cpu_write   = cwr;
    assign bus_z.dma_req     = req;
    assign bus_z.dma_address = daddr;
    assign bus_z.dma_dataOut = ddata;
    assign bus_z.dma_write   = dwr;
    assign bus_z.mem_dataIn  = mdin;

    cpu16_bus_arbiter #(.MAX_BURST(MAXB), .CPU_SLOTS(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    cpu16_bus_arbiter #(.MAX_BURST(MAXB), .CPU_SLOTS(0)) dut_z (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_z.slave)
    );

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    // Reference model per instance: who holds the bus, how long the grant has run,
    // how many CPU cycles have passed since the last handover
    int slots [2] = '{4, 0};
    bit m_hold [2];
    bit m_gnt  [2];
    bit m_rel  [2];
    int m_gcnt [2];
    int m_seen [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_hold[i] = 1'b0;
            m_gnt[i]  = 1'b0;
            m_rel[i]  = 1'b0;
            m_gcnt[i] = 0;
            m_seen[i] = slots[i];
        end
    endtask

    task automatic model_advance();
        for (int i = 0; i < 2; i++) begin
            if (m_gnt[i]) begin
                if (!req || m_gcnt[i] >= MAXB) begin
                    m_gnt[i]  = 1'b0;
                    m_hold[i] = 1'b0;
                    m_rel[i]  = 1'b1;
                end else begin
                    m_gcnt[i]++;
                end
            end else if (m_hold[i]) begin
                if (!req) begin
                    m_hold[i] = 1'b0;
                    m_rel[i]  = 1'b1;
                end else if (!busy) begin
                    m_gnt[i]  = 1'b1;
                    m_gcnt[i] = 1;
                end
            end else if (m_rel[i]) begin
                m_rel[i]  = 1'b0;
                m_seen[i] = 0;
            end else begin
                if (req && m_seen[i] >= slots[i]) begin
                    m_hold[i] = 1'b1;
                end else if (m_seen[i] < slots[i]) begin
                    m_seen[i]++;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_reset();
        else        model_advance();
        #1;
    endtask

    task automatic cmp_inst(input int i, input logic hold, input logic gnt,
                            input logic [15:0] addr, input logic [15:0] dout, input logic wr);
        logic [15:0] e_addr, e_dout;
        logic        e_wr;
        e_addr = m_gnt[i] ? daddr : caddr;
        e_dout = m_gnt[i] ? ddata : cdata;
        e_wr   = m_gnt[i] ? dwr : (m_rel[i] ? 1'b0 : cwr);
        check($sformatf("hold%0d", i), {31'd0, hold}, {31'd0, m_hold[i]});
        check($sformatf("gnt%0d", i),  {31'd0, gnt},  {31'd0, m_gnt[i]});
        check($sformatf("addr%0d", i), {16'd0, addr}, {16'd0, e_addr});
        check($sformatf("dout%0d", i), {16'd0, dout}, {16'd0, e_dout});
        check($sformatf("wr%0d", i),   {31'd0, wr},   {31'd0, e_wr});
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (run_cmp) begin
            cmp_inst(0, bus_a.cpu_hold, bus_a.dma_gnt, bus_a.mem_address, bus_a.mem_dataOut, bus_a.mem_write);
            cmp_inst(1, bus_z.cpu_hold, bus_z.dma_gnt, bus_z.mem_address, bus_z.mem_dataOut, bus_z.mem_write);
        end
    end

    task automatic rand_cpu();
        caddr = 16'($urandom);
        cdata = 16'($urandom);
        cwr   = 1'($urandom);
        busy  = 1'($urandom);
    endtask

    function automatic int first_idx(input logic [59:0] v, input int from, input logic val);
        for (int j = from; j < 60; j++) begin
            if (v[j] == val) return j;
        end
        return 60;
    endfunction

    logic [59:0] ga, gz, ha, mwa, mwz;
    int idle_hi;
    int n;
    int e2;
    bit seen_gnt;

    initial begin
        busy = 1'b1; caddr = '0; cdata = '0; cwr = 1'b0;
        req = 1'b0; daddr = '0; ddata = '0; dwr = 1'b0;
        mdin = 16'h00EA;
        reset = 1'b0;
        model_reset();
        run_cmp = 1'b1;
        repeat (3) step();
        reset = 1'b1;

        // CPU free-running, no DMA
        idle_hi = 0;
        for (int i = 0; i < 100; i++) begin
            rand_cpu();
            req = 1'b0;
            step();
            if (bus_a.cpu_hold || bus_a.dma_gnt || bus_z.cpu_hold || bus_z.dma_gnt) idle_hi++;
            if (bus_a.mem_address != caddr) idle_hi++;
        end
        check("idle_no_hold", idle_hi, 0);

        // Request with CPU busy for three sampled edges
        daddr = 16'h4000; ddata = 16'h1234; dwr = 1'b1;
        busy = 1'b1; req = 1'b1;
        step();
        check("req_hold_a", {31'd0, bus_a.cpu_hold}, 1);
        check("req_nognt_a", {31'd0, bus_a.dma_gnt}, 0);
        step();
        step();
        check("busy_nognt_a", {31'd0, bus_a.dma_gnt}, 0);
        check("busy_nognt_z", {31'd0, bus_z.dma_gnt}, 0);
        busy = 1'b0;
        step();
        check("gnt_a", {31'd0, bus_a.dma_gnt}, 1);
        check("gnt_z", {31'd0, bus_z.dma_gnt}, 1);
        check("gnt_addr_a", {16'd0, bus_a.mem_address}, 32'h4000);

        // Continuous request: burst lengths and CPU windows
        for (int i = 0; i < 60; i++) begin
            ga[i]  = bus_a.dma_gnt;
            gz[i]  = bus_z.dma_gnt;
            ha[i]  = bus_a.cpu_hold;
            mwa[i] = bus_a.mem_write;
            mwz[i] = bus_z.mem_write;
            step();
        end
        check("burst_len_a", first_idx(ga, 0, 1'b0), 16);
        check("burst_len_z", first_idx(gz, 0, 1'b0), 16);
        check("dma_write_a", {31'd0, mwa[0]}, 1);
        check("release_wr_a", {31'd0, mwa[16]}, 0);
        check("release_wr_z", {31'd0, mwz[16]}, 0);
        check("hold_low_a", first_idx(ha, 16, 1'b1) - 16, 6);
        check("regrant_a", first_idx(ga, 16, 1'b1), 23);
        check("burst2_len_a", first_idx(ga, 23, 1'b0) - 23, 16);
        check("regrant_z", first_idx(gz, 16, 1'b1), 19);
        e2 = first_idx(gz, 19, 1'b0);
        check("burst2_len_z", e2 - 19, 16);
        check("regrant3_z", first_idx(gz, e2, 1'b1), 38);

        // One-cycle request pulse withdrawn in HOLD_WAIT
        req = 1'b0; busy = 1'b1;
        repeat (10) step();
        req = 1'b1;
        step();
        check("pulse_hold_a", {31'd0, bus_a.cpu_hold}, 1);
        req = 1'b0;
        step();
        check("pulse_drop_hold_a", {31'd0, bus_a.cpu_hold}, 0);
        check("pulse_drop_gnt_a", {31'd0, bus_a.dma_gnt}, 0);
        check("pulse_drop_hold_z", {31'd0, bus_z.cpu_hold}, 0);
        step();
        check("pulse_after_gnt_a", {31'd0, bus_a.dma_gnt}, 0);

        // Reset in the middle of a burst
        repeat (10) step();
        busy = 1'b0; req = 1'b1;
        n = 0;
        while (!bus_a.dma_gnt && n < 20) begin
            step();
            n++;
        end
        check("rst_pre_gnt_timeout", {31'd0, bus_a.dma_gnt}, 1);
        repeat (4) step();
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_gnt_a", {31'd0, bus_a.dma_gnt}, 0);
        check("rst_hold_a", {31'd0, bus_a.cpu_hold}, 0);
        check("rst_gnt_z", {31'd0, bus_z.dma_gnt}, 0);
        step();
        reset = 1'b1;
        n = 0;
        while (!bus_a.dma_gnt && n < 20) begin
            step();
            n++;
        end
        check("post_rst_gnt_timeout", {31'd0, bus_a.dma_gnt}, 1);
        n = 0;
        while (bus_a.dma_gnt && n < 40) begin
            step();
            n++;
        end
        check("post_rst_burst_a", n, 16);

        // Randomized traffic checked cycle by cycle against the model
        seen_gnt = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rand_cpu();
            if ($urandom_range(0, 3) != 0) busy = 1'b0;
            if ($urandom_range(0, 11) == 0) req = ~req;
            daddr = 16'($urandom);
            ddata = 16'($urandom);
            dwr   = 1'($urandom);
            step();
            if (bus_a.dma_gnt) seen_gnt = 1'b1;
        end
        check("random_saw_grant", {31'd0, seen_gnt}, 1);

        run_cmp = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
